// File: rtl/demo_sequencer.sv
// Looping title-animation scheduler: BLANK -> SLIDE_IN -> HOLD -> SLIDE_OUT, advanced once per frame.
// Optional HOLD colour cycling is built when COLOR_CYCLE_EN is defined.
module demo_sequencer #(
  parameter int TARGET_X     = 64,
  parameter int TARGET_Y     = 0,
  parameter int STEP         = 8,
  parameter int BLANK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       skip,
  output logic [9:0] bmp_xorg,
  output logic [9:0] bmp_yorg,
  output logic       bmp_en,
  output logic [5:0] color,
  output logic [1:0] phase,
  output logic [7:0] frame_cnt,
  output logic       loop_done
);

  localparam logic [9:0]  X_HOME     = 10'(TARGET_X);
  localparam logic [9:0]  Y_HOME     = 10'(TARGET_Y);
  localparam logic [9:0]  Y_START    = 10'd480;
  localparam logic [9:0]  STEP_10    = 10'(STEP);
  localparam logic [10:0] STEP_11    = 11'(STEP);
  localparam logic [10:0] Y_LIMIT    = 11'(TARGET_Y + STEP);
  localparam logic [10:0] X_LIMIT    = 11'd640;
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK_FRAMES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [5:0]  WHITE      = 6'b111111;

  typedef enum logic [1:0] {
    BLANK     = 2'd0,
    SLIDE_IN  = 2'd1,
    HOLD      = 2'd2,
    SLIDE_OUT = 2'd3
  } phase_t;

  phase_t      state, state_n;
  logic [9:0]  x_n, y_n;
  logic [7:0]  dwell, dwell_n, fc_n;
  logic        en_n, ld_n;
  logic        step, last;
  logic [10:0] x_sum;

`ifdef COLOR_CYCLE_EN
  logic [2:0] pal, pal_n;
  logic [5:0] color_n;

  function automatic logic [5:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 6'b110000;
      3'd1:    palette = 6'b111100;
      3'd2:    palette = 6'b001100;
      3'd3:    palette = 6'b001111;
      3'd4:    palette = 6'b000011;
      default: palette = 6'b110011;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BLANK;
      bmp_xorg  <= X_HOME;
      bmp_yorg  <= Y_START;
      bmp_en    <= 1'b0;
      frame_cnt <= 8'd0;
      loop_done <= 1'b0;
      dwell     <= 8'd0;
`ifdef COLOR_CYCLE_EN
      pal       <= 3'd0;
      color     <= WHITE;
`endif
    end else begin
      state     <= state_n;
      bmp_xorg  <= x_n;
      bmp_yorg  <= y_n;
      bmp_en    <= en_n;
      frame_cnt <= fc_n;
      loop_done <= ld_n;
      dwell     <= dwell_n;
`ifdef COLOR_CYCLE_EN
      pal       <= pal_n;
      color     <= color_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    x_n     = bmp_xorg;
    y_n     = bmp_yorg;
    dwell_n = dwell;
    fc_n    = frame_cnt;
    ld_n    = 1'b0;
    step    = frame_tick & ~pause & ~skip;
    x_sum   = {1'b0, bmp_xorg} + STEP_11;

    // Compare happens before any subtract/add so the origin never wraps.
    case (state)
      BLANK:     last = (dwell == BLANK_LAST);
      SLIDE_IN:  last = ({1'b0, bmp_yorg} <= Y_LIMIT);
      HOLD:      last = (dwell == HOLD_LAST);
      default:   last = (x_sum >= X_LIMIT);
    endcase

    if (step)
      fc_n = frame_cnt + 8'd1;

    if (skip || (step && last)) begin
      state_n = phase_t'(state + 2'd1);
      dwell_n = 8'd0;
      case (state_n)
        SLIDE_IN:  y_n = Y_START;
        HOLD:      y_n = Y_HOME;
        SLIDE_OUT: x_n = X_HOME;
        default: begin
          x_n  = X_HOME;
          y_n  = Y_START;
          ld_n = 1'b1;
        end
      endcase
    end else if (step) begin
      case (state)
        SLIDE_IN:  y_n     = bmp_yorg - STEP_10;
        SLIDE_OUT: x_n     = x_sum[9:0];
        default:   dwell_n = dwell + 8'd1;
      endcase
    end

    en_n  = (state_n != BLANK);
    phase = state;
  end

`ifdef COLOR_CYCLE_EN
  // Palette restarts on every HOLD entry and steps every eighth HOLD frame.
  always_comb begin
    pal_n = pal;
    if (state_n == HOLD && state != HOLD)
      pal_n = 3'd0;
    else if (step && state == HOLD && dwell[2:0] == 3'd7)
      pal_n = (pal == 3'd5) ? 3'd0 : pal + 3'd1;
    color_n = (state_n == HOLD) ? palette(pal_n) : WHITE;
  end
`else
  assign color = WHITE;
`endif

endmodule
